// File: rtl/audio_path_sequencer.sv
// Sequences codec FIFO samples through a saturating power-of-two gain stage.
// Define PEAK_HOLD_EN for a decaying peak-hold meter; otherwise the meter shows the last sample.
module audio_path_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DECAY_SAMPLES  = 256,
    parameter int DROP_W         = 16
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              enable,
    input  logic [2:0]        gain_shift,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    input  logic [31:0]       right_channel_audio_in,
    output logic              read_audio_in,
    input  logic              audio_out_allowed,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    output logic              write_audio_out,
    output logic [30:0]       peak_level,
    output logic [DROP_W-1:0] drop_count,
    output logic              busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        WAIT_OUT,
        WRITE
    } state_t;

    state_t state, state_next;

    logic [31:0]   in_l;
    logic [31:0]   in_r;
    logic [2:0]    gain;
    logic [TW-1:0] t_cnt;
    logic          drop;
    logic [30:0]   abs_l;

    function automatic logic [31:0] sat_shl(input logic [31:0] x,
                                            input logic [2:0]  g);
        logic [39:0] w;
        w = {{8{x[31]}}, x} << g;
        // Bits above the result sign must all match it, else clamp
        if (w[39:31] == 9'h000 || w[39:31] == 9'h1FF)
            return w[31:0];
        return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    function automatic logic [30:0] mag(input logic [31:0] x);
        logic [31:0] n;
        if (x == 32'h8000_0000)
            return 31'h7FFF_FFFF;
        n = x[31] ? (~x + 32'd1) : x;
        return n[30:0];
    endfunction

    assign abs_l = mag(left_channel_audio_out);

    always_comb begin
        state_next = state;
        drop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (audio_in_available)
                    state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = enable ? WAIT_OUT : IDLE;
            end
            WAIT_OUT: begin
                if (audio_out_allowed) begin
                    state_next = WRITE;
                end else if (t_cnt == T_LAST) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state                   <= IDLE;
            read_audio_in           <= 1'b0;
            write_audio_out         <= 1'b0;
            busy                    <= 1'b0;
            in_l                    <= '0;
            in_r                    <= '0;
            gain                    <= '0;
            t_cnt                   <= '0;
            left_channel_audio_out  <= '0;
            right_channel_audio_out <= '0;
            drop_count              <= '0;
        end else begin
            state           <= state_next;
            // Strobes are registered from the next state so they align with it
            read_audio_in   <= (state_next == CAPTURE);
            write_audio_out <= (state_next == WRITE);
            busy            <= (state_next != IDLE);
            unique case (state)
                IDLE: begin
                    if (audio_in_available) begin
                        in_l <= left_channel_audio_in;
                        in_r <= right_channel_audio_in;
                        gain <= gain_shift;
                    end
                end
                CAPTURE: begin
                    left_channel_audio_out  <= sat_shl(in_l, gain);
                    right_channel_audio_out <= sat_shl(in_r, gain);
                    t_cnt                   <= '0;
                end
                WAIT_OUT: begin
                    if (!audio_out_allowed && !drop)
                        t_cnt <= t_cnt + TW'(1);
                end
                default: ;
            endcase
            if (drop && drop_count != '1)
                drop_count <= drop_count + DROP_W'(1);
        end
    end

`ifdef PEAK_HOLD_EN
    localparam int DW = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DECAY_SAMPLES - 1);

    logic [DW-1:0] d_cnt;
    logic [30:0]   peak_base;

    assign peak_base = (d_cnt == D_LAST) ? (peak_level >> 1) : peak_level;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            peak_level <= '0;
            d_cnt      <= '0;
        end else if (state == WRITE) begin
            peak_level <= (abs_l > peak_base) ? abs_l : peak_base;
            d_cnt      <= (d_cnt == D_LAST) ? '0 : d_cnt + DW'(1);
        end
    end
`else
    logic unused_decay;
    assign unused_decay = ^DECAY_SAMPLES;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            peak_level <= '0;
        else if (state == WRITE)
            peak_level <= abs_l;
    end
`endif

endmodule

// File: tb/tb_audio_path_sequencer.sv
// Scoreboard bench for audio_path_sequencer: stimulus queues expected samples,
// a monitor pops and compares on each write strobe.
module tb_audio_path_sequencer;

    localparam int TO = 8;
    localparam int DS = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic [2:0]    gain_shift;
    logic          avail;
    logic [31:0]   l_in;
    logic [31:0]   r_in;
    logic          rd;
    logic          allowed;
    logic [31:0]   l_out;
    logic [31:0]   r_out;
    logic          wr;
    logic [30:0]   peak;
    logic [DW-1:0] drops;
    logic          busy;

    always #5 clk = ~clk;

    audio_path_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .DECAY_SAMPLES (DS),
        .DROP_W        (DW)
    ) dut (
        .CLOCK_50               (clk),
        .resetn                 (resetn),
        .enable                 (enable),
        .gain_shift             (gain_shift),
        .audio_in_available     (avail),
        .left_channel_audio_in  (l_in),
        .right_channel_audio_in (r_in),
        .read_audio_in          (rd),
        .audio_out_allowed      (allowed),
        .left_channel_audio_out (l_out),
        .right_channel_audio_out(r_out),
        .write_audio_out        (wr),
        .peak_level             (peak),
        .drop_count             (drops),
        .busy                   (busy)
    );

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
    } smp_t;

    smp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_wr  = 0;
    int   n_rd  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    initial begin : monitor
        smp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rd) n_rd++;
            if (wr) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got l=%0h r=%0h want none",
                             l_out, r_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("left_out", {32'd0, l_out}, {32'd0, e.l});
                    chk("right_out", {32'd0, r_out}, {32'd0, e.r});
                end
            end
        end
    end

    task automatic offer(input logic [31:0] l, input logic [31:0] r,
                         input logic [2:0] g);
        int lat;
        @(negedge clk);
        l_in       = l;
        r_in       = r;
        gain_shift = g;
        avail      = 1'b1;
        lat        = 0;
        while (!rd && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        avail = 1'b0;
        chk("read_latency", 64'(lat), 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy=1 want 0");
        end
    endtask

    task automatic send(input logic [31:0] l, input logic [31:0] r,
                        input logic [2:0] g, input logic [31:0] el,
                        input logic [31:0] er);
        smp_t s;
        s.l = el;
        s.r = er;
        exp_q.push_back(s);
        offer(l, r, g);
        wait_idle();
    endtask

    int rd0;
    int wr0;

    initial begin
        resetn     = 1'b0;
        enable     = 1'b1;
        gain_shift = 3'd0;
        avail      = 1'b0;
        l_in       = '0;
        r_in       = '0;
        allowed    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_read", 64'(rd), 64'd0);
        chk("rst_write", 64'(wr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_left", 64'(l_out), 64'd0);
        chk("rst_peak", 64'(peak), 64'd0);
        chk("rst_drops", 64'(drops), 64'd0);
        resetn = 1'b1;

        send(32'h0000_1000, 32'h0000_0001, 3'd3, 32'h0000_8000, 32'h0000_0008);
        chk("busy_after", 64'(busy), 64'd0);
        chk("peak_first", 64'(peak), 64'h8000);

        send(32'h2000_0000, 32'h0000_0001, 3'd2, 32'h7FFF_FFFF, 32'h0000_0004);
        send(32'hC000_0000, 32'h7FFF_FFFF, 3'd2, 32'h8000_0000, 32'h7FFF_FFFF);
        send(32'h0000_0000, 32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 32'hFFFF_FF80);
        send(32'h1234_5678, 32'h8765_4321, 3'd0, 32'h1234_5678, 32'h8765_4321);

        allowed = 1'b0;
        wr0 = n_wr;
        offer(32'h0000_0100, 32'h0000_0100, 3'd0);
        repeat (8) @(negedge clk);
        chk("drop_pre_busy", 64'(busy), 64'd1);
        chk("drop_pre_cnt", 64'(drops), 64'd0);
        @(negedge clk);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_cnt", 64'(drops), 64'd1);
        chk("drop_nowrite", 64'(n_wr - wr0), 64'd0);

        exp_q.push_back('{l: 32'h0000_0200, r: 32'h0000_0300});
        offer(32'h0000_0200, 32'h0000_0300, 3'd0);
        repeat (8) @(negedge clk);
        chk("late_busy", 64'(busy), 64'd1);
        allowed = 1'b1;
        wait_idle();
        chk("late_cnt", 64'(drops), 64'd1);
        chk("late_write", 64'(n_wr - wr0), 64'd1);

        allowed = 1'b0;
        offer(32'h0000_AAAA, 32'h0000_5555, 3'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("mid_rst_left", 64'(l_out), 64'd0);
        chk("mid_rst_right", 64'(r_out), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_drops", 64'(drops), 64'd0);
        chk("mid_rst_peak", 64'(peak), 64'd0);
        repeat (2) @(negedge clk);
        resetn  = 1'b1;
        allowed = 1'b1;

        send(32'h0000_1000, 32'hFFFF_F000, 3'd0, 32'h0000_1000, 32'hFFFF_F000);
        chk("peak_w1", 64'(peak), 64'h1000);
        send(32'h0000_0010, 32'hFFFF_FFF0, 3'd0, 32'h0000_0010, 32'hFFFF_FFF0);
`ifdef PEAK_HOLD_EN
        chk("peak_w2", 64'(peak), 64'h1000);
`else
        chk("peak_w2", 64'(peak), 64'h10);
`endif
        send(32'h0000_0010, 32'hFFFF_FFF0, 3'd0, 32'h0000_0010, 32'hFFFF_FFF0);
        send(32'h0000_0010, 32'hFFFF_FFF0, 3'd0, 32'h0000_0010, 32'hFFFF_FFF0);
`ifdef PEAK_HOLD_EN
        chk("peak_w4", 64'(peak), 64'h800);
`else
        chk("peak_w4", 64'(peak), 64'h10);
`endif

        enable = 1'b0;
        rd0 = n_rd;
        wr0 = n_wr;
        for (int i = 0; i < 5; i++) begin
            offer(32'h4000_0000 + 32'(i), 32'h0000_0001, 3'd1);
            wait_idle();
        end
        chk("dis_reads", 64'(n_rd - rd0), 64'd5);
        chk("dis_writes", 64'(n_wr - wr0), 64'd0);
`ifdef PEAK_HOLD_EN
        chk("dis_peak", 64'(peak), 64'h800);
`else
        chk("dis_peak", 64'(peak), 64'h10);
`endif

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
